// File: rtl/signed_seq_divider.sv
// rtl/signed_seq_divider.sv - multi-cycle restoring signed integer divider
//
// Computes the signed quotient and remainder of A / B after a fixed latency.
// The quotient truncates toward zero and the remainder takes the sign of A.
// The operation is launched with a start/done handshake.
//
// Ports:
//   clk         in   system clock, rising-edge active
//   rst_n       in   asynchronous active-low reset
//   start       in   launch request, sampled only while idle
//   A           in   N-bit signed dividend
//   B           in   N-bit signed divisor
//   busy        out  operation in progress (CALC or FIX)
//   done        out  one-cycle pulse when Q/R/flags are updated
//   Q           out  N-bit signed quotient
//   R           out  N-bit signed remainder
//   div_by_zero out  B was zero (Q = -1, R = A)
//   overflow    out  A was the most negative value and B was -1 (Q wraps)

module signed_seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    // dq starts as |A| and is shifted left each step; the freed LSBs collect
    // quotient bits, so after N steps it holds |Q|.
    logic [N-1:0]  dq;
    logic [N-1:0]  div_mag;
    // The kept remainder is always below |B| <= 2^(N-1) (or at most |A| when
    // B is zero), so N bits suffice; the N+1-bit working value lives in
    // shifted/trial.
    logic [N-1:0]  rem;
    logic [CW-1:0] count;
    logic          sign_q;
    logic          sign_r;
    logic          dz_q;
    logic          ovf_q;

    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N:0]    shifted;
    logic [N:0]    trial;

    always_comb begin
        a_mag   = A[N-1] ? (~A + N'(1)) : A;
        b_mag   = B[N-1] ? (~B + N'(1)) : B;
        shifted = {rem, dq[N-1]};
        trial   = shifted - {1'b0, div_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq          <= '0;
            div_mag     <= '0;
            rem         <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dq      <= a_mag;
                        div_mag <= b_mag;
                        rem     <= '0;
                        count   <= CW'(N);
                        sign_q  <= A[N-1] ^ B[N-1];
                        sign_r  <= A[N-1];
                        dz_q    <= (B == '0);
                        ovf_q   <= (A == MIN_VAL) && (B == '1);
                    end
                end
                CALC: begin
                    // Restoring step: keep the trial difference only when it
                    // did not borrow.
                    dq    <= {dq[N-2:0], ~trial[N]};
                    rem   <= trial[N] ? shifted[N-1:0] : trial[N-1:0];
                    count <= count - CW'(1);
                end
                FIX: begin
                    // With B == 0 every trial succeeds, so rem ends at |A| and
                    // the sign fix-up below reproduces R = A; only Q needs
                    // forcing. The overflow case falls out of truncation.
                    if (dz_q) begin
                        Q <= '1;
                    end else begin
                        Q <= sign_q ? (~dq + N'(1)) : dq;
                    end
                    R           <= sign_r ? (~rem + N'(1)) : rem;
                    div_by_zero <= dz_q;
                    overflow    <= ovf_q;
                    done        <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
